atm_txn_ctrl: RTL
=================

# atm_txn_ctrl

Transaction controller for the ATM balance. Accepts deposit/withdraw requests through a valid/ready handshake, range-checks each one, commits legal ones to the balance register and reports completion status. The `balance` output directly feeds the seven-segment display stage. It is the sole owner of the account balance.

## Interface

Parameters:
- `BAL_W`, 16: balance and amount width in bits.
- `MAX_BAL`, 65535: largest legal balance; must fit in `BAL_W` bits.
- `INIT_BAL`, 0: balance value loaded on reset.
- `WD_LIMIT`, 500: cumulative withdrawal limit per window. Used only with `ATM_WITHDRAW_LIMIT_EN`.

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `txn_valid`, in, 1: request strobe.
- `txn_ready`, out, 1: high only in IDLE.
- `txn_op`, in, 2: 00 deposit, 01 withdraw, 10 new limit window, 11 illegal.
- `txn_amount`, in, `BAL_W`: transaction amount, unsigned.
- `balance`, out, `BAL_W`: committed balance, registered; goes to the display stage.
- `busy`, out, 1: high in CHECK, COMMIT and RESP.
- `done`, out, 1: one-cycle completion pulse.
- `status`, out, 2: 00 OK, 01 insufficient funds, 10 overflow, 11 limit exceeded or illegal op.

## Operation

- The state machine has four states: IDLE -> CHECK -> COMMIT -> RESP -> IDLE. Every transition is unconditional except leaving IDLE.
- Accept: `txn_valid && txn_ready` at a rising edge. `txn_op` and `txn_amount` are captured at that edge and later input changes are ignored.
- `txn_valid` while not ready is dropped. Requests are not queued.
- CHECK: computes and registers the result and status. All arithmetic is done at `BAL_W+1` bits.
  - Deposit: if `balance + amount > MAX_BAL`, status is 10; otherwise status is 00.
  - Withdraw: if `amount > balance`, status is 01. Otherwise the limit check applies (see Configuration). Otherwise status is 00. Insufficient funds takes priority over the limit check.
  - Amount 0: OK, no balance change.
  - Op 11: status 11, no effect.
- COMMIT: `balance` is written only when status is 00. Failed transactions leave the balance bit-identical. The balance never wraps and never saturates.
- RESP: `done` = 1 for exactly this cycle. `status` is updated at entry to RESP and holds until the next RESP.
- Reset, including reset in the middle of a transaction:
  - State returns to IDLE immediately.
  - `balance` = `INIT_BAL`, `txn_ready` = 1, `busy` = 0, `done` = 0, `status` = 00, withdrawn total = 0.
  - An in-flight transaction is discarded with no done pulse.

## Timing

- Accept at edge k. CHECK runs in cycle k..k+1. At edge k+2, `balance` takes its new value and `done` rises. At edge k+3, `done` falls and `txn_ready` = 1.
- The earliest next accept is edge k+4, so the minimum spacing is 4 cycles per transaction.
- `txn_ready` and `busy` are complementary registered outputs. No output depends combinationally on any input.

## Configuration

- Macro: `ATM_WITHDRAW_LIMIT_EN`.
- Defined:
  - A `BAL_W+1`-bit withdrawn-total register accumulates every committed withdrawal.
  - A withdraw with `total + amount > WD_LIMIT` gets status 11 and changes nothing.
  - Op 10 clears the total. It completes with status 00 and leaves the balance unchanged.
- Undefined:
  - The register and the check are absent.
  - Op 10 completes with status 00 and has no effect.
  - The `WD_LIMIT` parameter is ignored.

## Test plan

- Reset with `INIT_BAL`=100, then deposit 50 accepted at edge k -> `balance`=150 and `done`=1 at edge k+2, status 00, `txn_ready`=1 at edge k+3.
- Balance 150, withdraw 151 -> status 01, balance stays 150. Withdraw 150 -> status 00, balance 0.
- Balance 65500, deposit 36 -> status 10, balance unchanged. Deposit 35 -> balance 65535, status 00.
- With `ATM_WITHDRAW_LIMIT_EN`, balance 1000:
  - Withdraw 300, then 300 -> second gives status 11, balance 700.
  - Op 10, then withdraw 300 -> status 00, balance 400.
  - Without the macro, the same withdraw 300, then 300 sequence -> balance 400.
- Assert `rst` during COMMIT of withdraw 50 from 200 -> no done pulse, `balance`=`INIT_BAL`, `txn_ready`=1 immediately.
- Pulse `txn_valid` with deposit 9 while busy, then op 11 -> the dropped request has no effect; op 11 gives status 11 and the balance is unchanged.

Source files
------------

// File: rtl/atm_txn_ctrl.sv
// ATM balance transaction controller: valid/ready request intake, range check, commit, status pulse.
// Optional cumulative withdrawal limit enabled by defining ATM_WITHDRAW_LIMIT_EN.
module atm_txn_ctrl #(
    parameter int BAL_W    = 16,
    parameter int MAX_BAL  = 65535,
    parameter int INIT_BAL = 0,
    parameter int WD_LIMIT = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             txn_valid,
    output logic             txn_ready,
    input  logic [1:0]       txn_op,
    input  logic [BAL_W-1:0] txn_amount,
    output logic [BAL_W-1:0] balance,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [1:0] OP_DEP    = 2'b00;
    localparam logic [1:0] OP_WD     = 2'b01;
    localparam logic [1:0] OP_WIN    = 2'b10;

    localparam logic [1:0] STS_OK    = 2'b00;
    localparam logic [1:0] STS_INSUF = 2'b01;
    localparam logic [1:0] STS_OVF   = 2'b10;
    localparam logic [1:0] STS_LIM   = 2'b11;

    localparam logic [BAL_W:0]   MAX_EXT  = (BAL_W+1)'(MAX_BAL);
    localparam logic [BAL_W-1:0] INIT_VAL = BAL_W'(INIT_BAL);

    // WD_LIMIT is bounded below 2**BAL_W so the BAL_W+1 bit limit sum cannot wrap.
    if (MAX_BAL >= (1 << BAL_W) || INIT_BAL > MAX_BAL || WD_LIMIT >= (1 << BAL_W)) begin : g_bad_param
        $error("atm_txn_ctrl: parameter out of range");
    end

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [BAL_W-1:0] amt_q, amt_d;
    logic [1:0]       chk_status_q, chk_status_d;
    logic [BAL_W-1:0] res_q, res_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic [1:0]       status_q, status_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic [BAL_W:0]   amt_ext, bal_ext, sum_ext;

    assign amt_ext = {1'b0, amt_q};
    assign bal_ext = {1'b0, balance_q};
    assign sum_ext = bal_ext + amt_ext;

`ifdef ATM_WITHDRAW_LIMIT_EN
    localparam logic [BAL_W:0] WD_EXT = (BAL_W+1)'(WD_LIMIT);

    logic [BAL_W:0] total_q, total_d;
    logic [BAL_W:0] wd_sum;

    assign wd_sum = total_q + amt_ext;

    always_comb begin
        total_d = total_q;
        if (state_q == ST_COMMIT && chk_status_q == STS_OK) begin
            if (op_q == OP_WD)
                total_d = wd_sum;
            else if (op_q == OP_WIN)
                total_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) total_q <= '0;
        else     total_q <= total_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        amt_d   = amt_q;
        case (state_q)
            ST_IDLE: begin
                if (txn_valid) begin
                    state_d = ST_CHECK;
                    op_d    = txn_op;
                    amt_d   = txn_amount;
                end
            end
            ST_CHECK:  state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_RESP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        chk_status_d = chk_status_q;
        res_d        = res_q;
        if (state_q == ST_CHECK) begin
            chk_status_d = STS_OK;
            res_d        = balance_q;
            case (op_q)
                OP_DEP: begin
                    if (sum_ext > MAX_EXT) chk_status_d = STS_OVF;
                    else                   res_d = sum_ext[BAL_W-1:0];
                end
                OP_WD: begin
                    if (amt_ext > bal_ext) chk_status_d = STS_INSUF;
`ifdef ATM_WITHDRAW_LIMIT_EN
                    else if (wd_sum > WD_EXT) chk_status_d = STS_LIM;
`endif
                    else res_d = balance_q - amt_q;
                end
                OP_WIN:  ;
                default: chk_status_d = STS_LIM;
            endcase
        end
    end

    // res_q already holds the unchanged balance for every non-OK or no-effect case.
    always_comb begin
        balance_d = balance_q;
        status_d  = status_q;
        if (state_q == ST_COMMIT) begin
            status_d = chk_status_q;
            if (chk_status_q == STS_OK) balance_d = res_q;
        end
        done_d  = (state_q == ST_COMMIT);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            amt_q        <= '0;
            chk_status_q <= STS_OK;
            res_q        <= INIT_VAL;
            balance_q    <= INIT_VAL;
            status_q     <= STS_OK;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            amt_q        <= amt_d;
            chk_status_q <= chk_status_d;
            res_q        <= res_d;
            balance_q    <= balance_d;
            status_q     <= status_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign txn_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign status    = status_q;
    assign balance   = balance_q;

endmodule
